// File: rtl/tracer_adapter_stream_packer.sv
// Packs variable-length trace packets into a gap-free little-endian bit stream
// and hands it out as 32-bit words on a valid/ready handshake.
module tracer_adapter_stream_packer #(
    parameter int PKT_WIDTH = 128,
    parameter int LEN_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 packet_valid_i,
    output logic                 packet_ready_o,
    input  logic [PKT_WIDTH-1:0] packet_i,
    input  logic [LEN_WIDTH-1:0] packet_len_i,
    input  logic                 flush_i,
    input  logic                 enable_i,
    output logic [31:0]          data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [15:0]          dropped_o,
    output logic                 busy_o
);

    localparam int AW = PKT_WIDTH + 32;
    localparam int FW = LEN_WIDTH + 1;
    localparam logic [FW-1:0]        WORD_BITS = FW'(32);
    localparam logic [LEN_WIDTH-1:0] MAX_LEN   = LEN_WIDTH'(PKT_WIDTH);

    logic [AW-1:0]        r_acc;
    logic [FW-1:0]        r_fill;
    logic                 r_flush_pend;
    logic [15:0]          r_drop_cnt;

    logic                 w_word_full;
    logic                 w_pop;
    logic                 w_pad_pop;
    logic                 w_accept;
    logic                 w_len_zero;
    logic                 w_len_over;
    logic                 w_insert;
    logic                 w_drop;
    logic [PKT_WIDTH-1:0] w_mask;
    logic [PKT_WIDTH-1:0] w_pkt_masked;
    logic [AW-1:0]        w_acc_pop;
    logic [FW-1:0]        w_fill_pop;
    logic [AW-1:0]        w_acc_next;
    logic [FW-1:0]        w_fill_next;
    logic                 w_pend_next;

    // Both sides transfer on the edge where valid & ready are high. valid_o and
    // data_o come straight from registers and hold until popped; packet_ready_o
    // is registered-state only, so a pop never raises it in the same cycle.
    assign w_word_full    = (r_fill >= WORD_BITS);
    assign valid_o        = w_word_full | (r_flush_pend & (r_fill != '0));
    assign packet_ready_o = ~w_word_full & ~r_flush_pend;
    assign data_o         = r_acc[31:0];
    assign dropped_o      = r_drop_cnt;
    assign busy_o         = (r_fill != '0) | r_flush_pend;

    assign w_pop      = valid_o & ready_i;
    assign w_pad_pop  = w_pop & ~w_word_full;
    assign w_accept   = packet_valid_i & packet_ready_o;
    assign w_len_zero = (packet_len_i == '0);
    assign w_len_over = (packet_len_i > MAX_LEN);
    assign w_insert   = w_accept & ~w_len_zero & ~w_len_over & enable_i;
    assign w_drop     = w_accept & ~w_len_zero & (w_len_over | ~enable_i);

    // A shift of PKT_WIDTH or more yields zero, so full-width packets keep every bit.
    assign w_mask       = ~({PKT_WIDTH{1'b1}} << packet_len_i);
    assign w_pkt_masked = packet_i & w_mask;

    // Pop is applied first; a packet inserted in the same cycle lands at the post-pop fill.
    assign w_acc_pop  = w_pop ? (r_acc >> 32) : r_acc;
    assign w_fill_pop = !w_pop ? r_fill : (w_pad_pop ? '0 : r_fill - WORD_BITS);

    assign w_acc_next  = w_insert ? (w_acc_pop | ({{32{1'b0}}, w_pkt_masked} << w_fill_pop))
                                  : w_acc_pop;
    assign w_fill_next = w_insert ? (w_fill_pop + {1'b0, packet_len_i}) : w_fill_pop;

    // A flush that finds nothing left to pad retires without producing a word.
    assign w_pend_next = ((r_flush_pend & ~w_pad_pop) | (flush_i & ~r_flush_pend))
                         & (w_fill_next != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_acc        <= '0;
            r_fill       <= '0;
            r_flush_pend <= 1'b0;
            r_drop_cnt   <= '0;
        end else begin
            r_acc        <= w_acc_next;
            r_fill       <= w_fill_next;
            r_flush_pend <= w_pend_next;
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_tracer_adapter_stream_packer.sv
// Bench for tracer_adapter_stream_packer: directed scenarios plus random traffic,
// checked every cycle against a bit-queue model of the output stream.
module tb_tracer_adapter_stream_packer;

    localparam int PKT_WIDTH = 128;
    localparam int LEN_WIDTH = 8;

    logic                 clk = 1'b0;
    logic                 rst_i = 1'b1;
    logic                 packet_valid_i = 1'b0;
    logic                 packet_ready_o;
    logic [PKT_WIDTH-1:0] packet_i = '0;
    logic [LEN_WIDTH-1:0] packet_len_i = '0;
    logic                 flush_i = 1'b0;
    logic                 enable_i = 1'b1;
    logic [31:0]          data_o;
    logic                 valid_o;
    logic                 ready_i = 1'b1;
    logic [15:0]          dropped_o;
    logic                 busy_o;

    tracer_adapter_stream_packer #(.PKT_WIDTH(PKT_WIDTH), .LEN_WIDTH(LEN_WIDTH)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .packet_valid_i (packet_valid_i),
        .packet_ready_o (packet_ready_o),
        .packet_i       (packet_i),
        .packet_len_i   (packet_len_i),
        .flush_i        (flush_i),
        .enable_i       (enable_i),
        .data_o         (data_o),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .dropped_o      (dropped_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Stream model: words owed to the consumer, residual bits not yet a word,
    // whether the queued tail word is a flush-padded one, and the drop count.
    logic [31:0] exp_q[$];
    logic        res_bits[$];
    bit          pad_pend = 0;
    int          exp_drops = 0;
    logic [31:0] got_log[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        res_bits.delete();
        pad_pend  = 0;
        exp_drops = 0;
    endtask

    // Monitor: compare outputs with the model, then advance the model by what
    // the coming edge will transfer.
    always @(negedge clk) begin
        if (!rst_i) begin
            logic [31:0] exp_data;
            bit          pend_before;
            exp_data = '0;
            if (exp_q.size() != 0) exp_data = exp_q[0];
            else for (int i = 0; i < res_bits.size(); i++) exp_data[i] = res_bits[i];
            check("valid", {31'b0, valid_o}, {31'b0, exp_q.size() != 0});
            check("data", data_o, exp_data);
            check("pkt_ready", {31'b0, packet_ready_o}, {31'b0, exp_q.size() == 0 && !pad_pend});
            check("busy", {31'b0, busy_o}, {31'b0, exp_q.size() != 0 || res_bits.size() != 0});
            check("dropped", {16'b0, dropped_o}, exp_drops);

            pend_before = pad_pend;
            if (valid_o && ready_i) begin
                got_log.push_back(data_o);
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                if (exp_q.size() == 0) pad_pend = 0;
            end
            if (packet_valid_i && packet_ready_o && packet_len_i != 0) begin
                if (packet_len_i > PKT_WIDTH || !enable_i) begin
                    if (exp_drops < 65535) exp_drops++;
                end else begin
                    for (int i = 0; i < packet_len_i; i++) res_bits.push_back(packet_i[i]);
                    while (res_bits.size() >= 32) begin
                        logic [31:0] w;
                        for (int i = 0; i < 32; i++) w[i] = res_bits.pop_front();
                        exp_q.push_back(w);
                    end
                end
            end
            if (flush_i && !pend_before && res_bits.size() != 0) begin
                logic [31:0] w;
                w = '0;
                for (int i = 0; i < res_bits.size(); i++) w[i] = res_bits[i];
                res_bits.delete();
                exp_q.push_back(w);
                pad_pend = 1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input int len, input logic [PKT_WIDTH-1:0] data);
        bit done, rdy;
        done = 0;
        packet_valid_i = 1'b1;
        packet_len_i   = LEN_WIDTH'(len);
        packet_i       = data;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            rdy = packet_ready_o;
            @(posedge clk);
            #1;
            if (rdy) begin
                done = 1;
                break;
            end
        end
        packet_valid_i = 1'b0;
        check("send_accepted", {31'b0, done}, 32'd1);
    endtask

    task automatic pulse_flush();
        flush_i = 1'b1;
        tick(1);
        flush_i = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles);
        bit done;
        done = 0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (!valid_o) begin
                done = 1;
                break;
            end
        end
        tick(1);
        check("drain_done", {31'b0, done}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, data_o, 32'h0);
        check({tag, "_valid"}, {31'b0, valid_o}, 32'd0);
        check({tag, "_ready"}, {31'b0, packet_ready_o}, 32'd1);
        check({tag, "_dropped"}, {16'b0, dropped_o}, 32'd0);
        check({tag, "_busy"}, {31'b0, busy_o}, 32'd0);
    endtask

    initial begin
        #2;
        check_reset_outputs("por");
        tick(2);
        rst_i = 1'b0;
        tick(2);

        // Two packets stream straight through.
        got_log.delete();
        send_pkt(32, 128'hDEADBEEF);
        send_pkt(64, 128'h11223344_55667788);
        wait_drain(20);
        check("s1_count", got_log.size(), 32'd3);
        if (got_log.size() == 3) begin
            check("s1_w0", got_log[0], 32'hDEADBEEF);
            check("s1_w1", got_log[1], 32'h55667788);
            check("s1_w2", got_log[2], 32'h11223344);
        end
        check("s1_busy", {31'b0, busy_o}, 32'd0);

        // Packing across a packet boundary, garbage above len must be masked.
        got_log.delete();
        send_pkt(4, 128'hFFFF_FFF0_0000_00FA);
        send_pkt(32, 128'hABCD_0000_0000_0000_0000_0000_1234_5678);
        wait_drain(20);
        check("s2_count", got_log.size(), 32'd1);
        if (got_log.size() == 1) check("s2_w0", got_log[0], 32'h2345678A);
        check("s2_residual", data_o, 32'h1);
        check("s2_ready", {31'b0, packet_ready_o}, 32'd1);

        // Flush the residual, then a flush with nothing to pad.
        got_log.delete();
        pulse_flush();
        wait_drain(20);
        check("s3_count", got_log.size(), 32'd1);
        if (got_log.size() == 1) check("s3_w0", got_log[0], 32'h00000001);
        check("s3_busy", {31'b0, busy_o}, 32'd0);
        pulse_flush();
        tick(4);
        check("s3_empty_flush", got_log.size(), 32'd1);

        // Backpressure on a full-width packet.
        got_log.delete();
        ready_i = 1'b0;
        send_pkt(128, 128'h44444444_33333333_22222222_11111111);
        tick(10);
        check("s4_held_valid", {31'b0, valid_o}, 32'd1);
        check("s4_held_data", data_o, 32'h11111111);
        check("s4_held_ready", {31'b0, packet_ready_o}, 32'd0);
        ready_i = 1'b1;
        wait_drain(20);
        check("s4_count", got_log.size(), 32'd4);
        for (int i = 0; i < 4 && i < got_log.size(); i++)
            check("s4_word", got_log[i], {4{8'(8'h11 * (i + 1))}});

        // Drops: disabled channel and oversize packet.
        got_log.delete();
        enable_i = 1'b0;
        for (int i = 0; i < 3; i++) send_pkt(32, 128'hCAFE0000 + i);
        enable_i = 1'b1;
        send_pkt(200, {4{32'h5A5A5A5A}});
        tick(3);
        check("s5_dropped", {16'b0, dropped_o}, 32'd4);
        check("s5_no_words", got_log.size(), 32'd0);
        enable_i       = 1'b0;
        packet_valid_i = 1'b1;
        packet_len_i   = 8'd8;
        tick(70000);
        packet_valid_i = 1'b0;
        enable_i       = 1'b1;
        tick(1);
        check("s5_saturated", {16'b0, dropped_o}, 32'h0000FFFF);

        // Reset while words are waiting.
        ready_i = 1'b0;
        send_pkt(96, {32'h0, 32'h33333333, 32'h22222222, 32'h11111111});
        tick(2);
        check("s6_pre_valid", {31'b0, valid_o}, 32'd1);
        #1;
        rst_i = 1'b1;
        #1;
        check_reset_outputs("s6_rst");
        model_clear();
        tick(2);
        rst_i   = 1'b0;
        ready_i = 1'b1;
        got_log.delete();
        send_pkt(32, 128'h600DF00D);
        wait_drain(20);
        tick(3);
        check("s6_count", got_log.size(), 32'd1);
        if (got_log.size() == 1) check("s6_w0", got_log[0], 32'h600DF00D);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            int sel;
            sel            = $urandom_range(0, 9);
            packet_valid_i = $urandom_range(0, 1) == 1;
            packet_len_i   = (sel == 0) ? 8'd0 :
                             (sel == 1) ? LEN_WIDTH'($urandom_range(129, 255)) :
                                          LEN_WIDTH'($urandom_range(1, 128));
            packet_i       = {$urandom, $urandom, $urandom, $urandom};
            enable_i       = $urandom_range(0, 9) != 0;
            ready_i        = $urandom_range(0, 3) != 0;
            flush_i        = $urandom_range(0, 15) == 0;
            tick(1);
        end
        packet_valid_i = 1'b0;
        flush_i        = 1'b0;
        ready_i        = 1'b1;
        wait_drain(50);
        pulse_flush();
        wait_drain(10);
        tick(2);
        check("rand_idle", {31'b0, busy_o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
